// File: rtl/decomp_ctrl.sv
// Decompressor control: fetches imem words, forwards raw instructions and expands marker-tagged
// bundles token by token via the token table. Optional counters under `DECOMP_STATS_EN`.
module decomp_ctrl #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     SIZE     = 23,
  parameter int unsigned     TOKW     = 8,
  parameter logic [7:0]      MARKER   = 8'hFF,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [SIZE-1:0]  redirect_pc,
  output logic             im_en,
  output logic [SIZE-1:0]  im_addr,
  input  logic [WIDTH-1:0] im_rdata,
  output logic             tt_en,
  output logic [TOKW-1:0]  tt_addr,
  input  logic [WIDTH-1:0] tt_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [SIZE-1:0]  out_pc,
  output logic             out_cmp
`ifdef DECOMP_STATS_EN
  ,
  output logic [31:0]      stat_bundles,
  output logic [31:0]      stat_tokens
`endif
);

  localparam int unsigned NTOK = (WIDTH - 8) / TOKW;
  localparam int unsigned IDXW = (NTOK > 1) ? $clog2(NTOK) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StTreq, StTload, StOut} state_e;

  state_e             state_q;
  logic [SIZE-1:0]    pc_q;
  logic [WIDTH-1:0]   bundle_q;
  logic [IDXW-1:0]    idx_q;

  function automatic logic [TOKW-1:0] tok(input logic [WIDTH-1:0] w, input logic [IDXW-1:0] i);
    return w[i*TOKW +: TOKW];
  endfunction

  logic            is_bundle;
  logic            more_tok;
  logic [IDXW-1:0] idx_nxt;

  assign is_bundle = (im_rdata[WIDTH-1 -: 8] == MARKER);
  assign idx_nxt   = idx_q + IDXW'(1);
  // Short-circuit keeps the next-token probe inside the bundle when idx is the last slot.
  assign more_tok  = (32'(idx_q) + 32'd1 < NTOK) && (tok(bundle_q, idx_nxt) != '0);

  assign im_en   = (state_q == StFetch);
  assign im_addr = pc_q;
  assign tt_en   = (state_q == StTreq);
  assign tt_addr = tok(bundle_q, idx_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      bundle_q     <= '0;
      idx_q        <= '0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_cmp      <= 1'b0;
`ifdef DECOMP_STATS_EN
      stat_bundles <= '0;
      stat_tokens  <= '0;
`endif
    end else if (redirect) begin
      // A transfer on the redirect edge is still consumed, so it still counts.
`ifdef DECOMP_STATS_EN
      if (state_q == StOut && out_valid && out_ready && out_cmp) begin
        stat_tokens <= stat_tokens + 32'd1;
      end
`endif
      state_q   <= StFetch;
      pc_q      <= redirect_pc;
      idx_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StFetch;
        StFetch: state_q <= StLoad;
        StLoad: begin
          bundle_q <= im_rdata;
          idx_q    <= '0;
          if (!is_bundle) begin
            out_instr <= im_rdata;
            out_cmp   <= 1'b0;
            out_pc    <= pc_q;
            out_valid <= 1'b1;
            state_q   <= StOut;
          end else begin
`ifdef DECOMP_STATS_EN
            stat_bundles <= stat_bundles + 32'd1;
`endif
            if (tok(im_rdata, '0) != '0) begin
              state_q <= StTreq;
            end else begin
              pc_q    <= pc_q + SIZE'(1);
              state_q <= StFetch;
            end
          end
        end
        StTreq:  state_q <= StTload;
        StTload: begin
          out_instr <= tt_rdata;
          out_cmp   <= 1'b1;
          out_pc    <= pc_q;
          out_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef DECOMP_STATS_EN
            if (out_cmp) stat_tokens <= stat_tokens + 32'd1;
`endif
            if (out_cmp && more_tok) begin
              idx_q   <= idx_nxt;
              state_q <= StTreq;
            end else begin
              pc_q    <= pc_q + SIZE'(1);
              state_q <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
